// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous-read data RAM.
// Port A has priority; a starvation counter forces one port B grant after STARVE_LIMIT refusals.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic [3:0]  a_wen,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic [3:0]  b_wen,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [31:0] b_rdata,
   output logic        ram_en,
   output logic [3:0]  ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_A    = 2'd1,
      RESP_B    = 2'd2
   } resp_e;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   resp_e            resp_q, resp_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic [31:0]      a_rdata_q, a_rdata_d;
   logic [31:0]      b_rdata_q, b_rdata_d;
   logic             force_b;

   assign force_b = b_req && (starve_q == LIMIT);
   assign a_gnt   = a_req && !force_b;
   assign b_gnt   = b_req && (!a_req || force_b);
   assign ram_en  = a_gnt | b_gnt;

   always_comb begin
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
      ram_wen   = 4'b0000;
      if (b_gnt) begin
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
         ram_wen   = b_wen;
      end else if (a_gnt) begin
         ram_wen = a_wen;
      end
   end

   // Owner of the read data the RAM will present next cycle.
   always_comb begin
      resp_d = RESP_NONE;
      if (a_gnt && (a_wen == 4'b0000)) begin
         resp_d = RESP_A;
      end else if (b_gnt && (b_wen == 4'b0000)) begin
         resp_d = RESP_B;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!b_req || b_gnt) begin
         starve_d = '0;
      end else if (starve_q != LIMIT) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // A response is dropped while reset is held so nothing in flight survives it.
   assign a_rvalid = (resp_q == RESP_A) && !reset;
   assign b_rvalid = (resp_q == RESP_B) && !reset;

   assign a_rdata_d = a_rvalid ? ram_rdata : a_rdata_q;
   assign b_rdata_d = b_rvalid ? ram_rdata : b_rdata_q;
   assign a_rdata   = a_rdata_d;
   assign b_rdata   = b_rdata_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_q    <= RESP_NONE;
         starve_q  <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         resp_q    <= resp_d;
         starve_q  <= starve_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous-read data RAM between two requesters.
- Port A is the MEM stage load/store path and has priority. Port B is the secondary requester (debug/display reader or DMA-style writer).
- Issues at most one RAM access per cycle, routes each read response back to its owner one cycle later, and holds it there.
- A starvation counter guarantees port B forward progress under a continuous port A stream.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles port B may be refused while requesting before it is forced one grant (legal 1..15).
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A access request
- a_wen  in  4  port A byte write enables; 0000 = read
- a_addr  in  32  port A byte address
- a_wdata  in  32  port A write data, already lane-aligned
- a_gnt  out  1  port A request accepted this cycle (combinational)
- a_rvalid  out  1  port A read data valid (one cycle after a granted read)
- a_rdata  out  32  port A read data, held
- b_req  in  1  port B access request
- b_wen  in  4  port B byte write enables
- b_addr  in  32  port B byte address
- b_wdata  in  32  port B write data
- b_gnt  out  1  port B request accepted this cycle (combinational)
- b_rvalid  out  1  port B read data valid
- b_rdata  out  32  port B read data, held
- ram_en  out  1  RAM access strobe
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  32  RAM byte address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read

Behaviour:
Grant selection (combinational, every cycle):
- force_b = b_req && (starve_cnt == STARVE_LIMIT).
- a_gnt = a_req && !force_b.
- b_gnt = b_req && (!a_req || force_b).
- At most one grant is ever set.
- Requests stay asserted with stable address and data until granted; a requester may drop a request before its grant.

RAM drive:
- ram_en = a_gnt | b_gnt.
- ram_addr, ram_wen and ram_wdata come from the granted port.
- When nothing is granted: ram_wen = 0000 (all other RAM outputs don't-care).
- Writes complete in the grant cycle and produce no response.

Response owner FSM (registered, 2 bits):
- States: RESP_NONE, RESP_A, RESP_B.
- Next state = RESP_A if a_gnt && a_wen==0; RESP_B if b_gnt && b_wen==0; otherwise RESP_NONE.
- RESP_A: a_rvalid=1 for exactly that cycle; a_rdata captures ram_rdata into a register on that edge.
- RESP_B: same for port B.
- Back-to-back reads pipeline at one per cycle with no bubble (e.g. A then B gives A response, then B response).

Held read data:
- a_rdata and b_rdata are registers.
- Each updates only on its own port's response and otherwise holds its last value.

Starvation counter starve_cnt (CNT_W bits):
- Clears to 0 when b_gnt=1 or b_req=0.
- Increments by 1 when b_req && !b_gnt.
- Saturates at STARVE_LIMIT; never wraps.

Reset (synchronous, reset=1 at a rising edge):
- FSM goes to RESP_NONE; starve_cnt=0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
- Grants are combinational and may assert during reset, but any response in flight is discarded: the rvalid is suppressed on the cycle after reset deasserts.

Boundary conditions:
- Both ports request in the same cycle: A wins unless force_b.
- force_b while A requests: A is stalled exactly one cycle and is granted the following cycle.
- Granted write: owner FSM goes to RESP_NONE; any earlier read response is still delivered.

Latency:
- Grant in request cycle (0 wait when uncontended).
- Read data 1 cycle after grant.

Test Plan:
1. A-only read at 0x00000010, RAM returns 0xDEADBEEF: a_gnt=1 in cycle 0; a_rvalid=1 and a_rdata=0xDEADBEEF in cycle 1; a_rdata holds after that; b_rvalid stays 0.
2. A write (a_wen=1111, 0x20, 0x12345678) together with a B read of 0x24: a_gnt=1, b_gnt=0, ram_wen=1111. Next cycle b_gnt=1, with b_rvalid in the cycle after.
3. Starvation: a_req held high, b_req held high from cycle 0, STARVE_LIMIT=4. b_gnt=1 first in cycle 4 (a_gnt=0 that cycle); a_gnt resumes in cycle 5; starve_cnt returns to 0.
4. Back-to-back reads A@0x0, B@0x4, A@0x8 in consecutive cycles: responses A, B, A in consecutive cycles, each rdata matching its own address's data; no cross-routing.
5. reset asserted the cycle after a granted A read: a_rvalid stays 0 and a_rdata=0 after reset; starve_cnt=0; the next read works normally.
6. b_req dropped after 3 refused cycles, then reasserted: starve_cnt restarts at 0, and a forced grant needs 4 further refused cycles.
